lcd_bus_rx: RTL and testbench

- Peripheral-side receiver for the HD44780-style parallel LCD bus (rs/rw/en/8-bit data) that our calculator controllers drive.
- Decodes instructions, keeps a 2x16 character DDRAM mirror, address counter and mode flags, and models the busy window.
- Used as an on-chip display mirror (readback for the result path) and as the synthesizable responder in LCD controller benches.

---
 rtl/lcd_pkg.sv | 74 +++++++
 rtl/lcd_edge_sync.sv | 27 ++
 rtl/lcd_bus_rx.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_bus_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, instruction bit positions and DDRAM address helpers for the LCD bus receiver.
package lcd_pkg;

    typedef enum logic [1:0] {StIdle, StExec, StClrFill, StClrWait} lcd_state_e;

    typedef struct packed {
        logic disp_on;
        logic cursor_on;
        logic blink_on;
        logic inc_mode;
        logic shift_mode;
        logic func_8bit;
        logic func_2line;
    } lcd_flags_t;

    localparam lcd_flags_t FLAGS_RST = '{inc_mode: 1'b1, func_8bit: 1'b1, default: 1'b0};

    // Opcode is identified by its highest set bit
    localparam int unsigned BIT_SET_DDRAM = 7;
    localparam int unsigned BIT_SET_CGRAM = 6;
    localparam int unsigned BIT_FUNC      = 5;
    localparam int unsigned BIT_SHIFT     = 4;
    localparam int unsigned BIT_DISP      = 3;
    localparam int unsigned BIT_ENTRY     = 2;
    localparam int unsigned BIT_HOME      = 1;
    localparam int unsigned BIT_CLEAR     = 0;

    localparam int unsigned BIT_FUNC_DL  = 4;
    localparam int unsigned BIT_FUNC_N   = 3;
    localparam int unsigned BIT_SHIFT_SC = 3;
    localparam int unsigned BIT_SHIFT_RL = 2;
    localparam int unsigned BIT_DISP_D   = 2;
    localparam int unsigned BIT_DISP_C   = 1;
    localparam int unsigned BIT_DISP_B   = 0;
    localparam int unsigned BIT_ENTRY_ID = 1;
    localparam int unsigned BIT_ENTRY_S  = 0;

    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam logic [6:0] LINE0_LAST  = 7'h27;
    localparam logic [6:0] LINE1_LAST  = 7'h67;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } ddram_idx_t;

    function automatic ddram_idx_t ac_to_index(input logic [6:0] ac, input logic [6:0] line_len);
        ddram_idx_t r;
        r.hit = 1'b0;
        r.idx = '0;
        if (ac < line_len) begin
            r.hit = 1'b1;
            r.idx = ac[4:0];
        end else if (ac >= LINE1_BASE && ac < LINE1_BASE + line_len) begin
            r.hit = 1'b1;
            r.idx = 5'(ac - LINE1_BASE + line_len);
        end
        return r;
    endfunction

    // Address counter walks 0x00..0x27 then 0x40..0x67, wrapping in both directions
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == LINE0_LAST) return LINE1_BASE;
            if (ac == LINE1_LAST) return 7'h00;
            return ac + 7'd1;
        end
        if (ac == 7'h00) return LINE1_LAST;
        if (ac == LINE1_BASE) return LINE0_LAST;
        return ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_edge_sync.sv
// Two-flop synchronizer for the asynchronous LCD enable strobe with rise/fall pulse detect.
module lcd_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= en_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/lcd_bus_rx.sv
// HD44780-style bus receiver: instruction decode, 2-line DDRAM mirror and busy window.
// Define LCD_READ_EN to enable bus reads (busy/AC and DDRAM readback).
module lcd_bus_rx
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CMD_CYC = 2000,
    parameter int unsigned BUSY_CLR_CYC = 76500,
    parameter int unsigned LINE_LEN     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_d_in,
    output logic [7:0] lcd_d_out,
    output logic       lcd_d_oe,
    input  logic [4:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       shift_mode,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       cmd_strobe,
    output logic       err_busy
);

    localparam int unsigned DEPTH = 2 * LINE_LEN;
    localparam int unsigned CNT_W = $clog2(BUSY_CLR_CYC + 1);

    logic en_rise, en_fall;

    lcd_edge_sync u_en_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .en_i  (lcd_en),
        .rise_o(en_rise),
        .fall_o(en_fall)
    );

    logic       bus_rs_q, bus_rw_q;
    logic [7:0] bus_d_q;
    logic       cap_vld_q, cap_rs_q, cap_rw_q;
    logic [7:0] cap_d_q;

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       fill_q, fill_d;
    logic [6:0]       ac_q, ac_d;
    lcd_flags_t       flags_q, flags_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic             strobe_q, strobe_d, err_q, err_d;
    logic [7:0]       d_out_q, d_out_d;
    logic             d_oe_q, d_oe_d;
    logic             is_busy;
    ddram_idx_t       ac_idx;

    assign is_busy = (state_q != StIdle);
    assign ac_idx  = ac_to_index(ac_q, 7'(LINE_LEN));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        ac_d     = ac_q;
        flags_d  = flags_q;
        mem_d    = mem_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        d_out_d  = d_out_q;
        d_oe_d   = d_oe_q;

        unique case (state_q)
            StIdle: ;
            StExec, StClrWait: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            StClrFill: begin
                mem_d[fill_q] = ASCII_SPACE;
                fill_d        = fill_q + 5'd1;
                cnt_d         = cnt_q - CNT_W'(1);
                if (fill_q == 5'(DEPTH - 1)) state_d = StClrWait;
            end
            default: state_d = StIdle;
        endcase

        if (cap_vld_q) begin
            if (!cap_rw_q && is_busy) begin
                err_d = 1'b1;
            end else if (!cap_rw_q && cap_rs_q) begin
                if (ac_idx.hit) mem_d[ac_idx.idx] = cap_d_q;
                ac_d     = ac_step(ac_q, flags_q.inc_mode);
                strobe_d = 1'b1;
                state_d  = StExec;
                cnt_d    = CNT_W'(BUSY_CMD_CYC - 1);
            end else if (!cap_rw_q && cap_d_q != 8'h00) begin
                strobe_d = 1'b1;
                state_d  = StExec;
                cnt_d    = CNT_W'(BUSY_CMD_CYC - 1);
                if (cap_d_q[BIT_SET_DDRAM]) begin
                    ac_d = cap_d_q[6:0];
                end else if (cap_d_q[BIT_SET_CGRAM]) begin
                    // CGRAM is not mirrored; only the busy window applies
                end else if (cap_d_q[BIT_FUNC]) begin
                    flags_d.func_8bit  = cap_d_q[BIT_FUNC_DL];
                    flags_d.func_2line = cap_d_q[BIT_FUNC_N];
                end else if (cap_d_q[BIT_SHIFT]) begin
                    if (!cap_d_q[BIT_SHIFT_SC]) ac_d = ac_step(ac_q, cap_d_q[BIT_SHIFT_RL]);
                end else if (cap_d_q[BIT_DISP]) begin
                    flags_d.disp_on   = cap_d_q[BIT_DISP_D];
                    flags_d.cursor_on = cap_d_q[BIT_DISP_C];
                    flags_d.blink_on  = cap_d_q[BIT_DISP_B];
                end else if (cap_d_q[BIT_ENTRY]) begin
                    flags_d.inc_mode   = cap_d_q[BIT_ENTRY_ID];
                    flags_d.shift_mode = cap_d_q[BIT_ENTRY_S];
                end else if (cap_d_q[BIT_HOME]) begin
                    ac_d    = '0;
                    cnt_d   = CNT_W'(BUSY_CLR_CYC - 1);
                    state_d = StClrWait;
                end else if (cap_d_q[BIT_CLEAR]) begin
                    ac_d             = '0;
                    flags_d.inc_mode = 1'b1;
                    cnt_d            = CNT_W'(BUSY_CLR_CYC - 1);
                    fill_d           = '0;
                    state_d          = StClrFill;
                end
`ifdef LCD_READ_EN
            end else if (cap_rw_q && !cap_rs_q) begin
                strobe_d = 1'b1;
            end else if (cap_rw_q && !is_busy) begin
                ac_d     = ac_step(ac_q, flags_q.inc_mode);
                strobe_d = 1'b1;
                state_d  = StExec;
                cnt_d    = CNT_W'(BUSY_CMD_CYC - 1);
`endif
            end
        end

`ifdef LCD_READ_EN
        if (en_rise && bus_rw_q) begin
            d_oe_d  = 1'b1;
            d_out_d = bus_rs_q ? (ac_idx.hit ? mem_q[ac_idx.idx] : ASCII_SPACE)
                               : {is_busy, ac_q};
        end
        if (en_fall) d_oe_d = 1'b0;
`else
        d_oe_d  = 1'b0;
        d_out_d = '0;
`endif
    end

`ifndef LCD_READ_EN
    logic unused_rise;
    assign unused_rise = en_rise;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rs_q  <= 1'b0;
            bus_rw_q  <= 1'b0;
            bus_d_q   <= '0;
            cap_vld_q <= 1'b0;
            cap_rs_q  <= 1'b0;
            cap_rw_q  <= 1'b0;
            cap_d_q   <= '0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            fill_q    <= '0;
            ac_q      <= '0;
            flags_q   <= FLAGS_RST;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            d_out_q   <= '0;
            d_oe_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= ASCII_SPACE;
        end else begin
            bus_rs_q  <= lcd_rs;
            bus_rw_q  <= lcd_rw;
            bus_d_q   <= lcd_d_in;
            cap_vld_q <= en_fall;
            if (en_fall) begin
                cap_rs_q <= bus_rs_q;
                cap_rw_q <= bus_rw_q;
                cap_d_q  <= bus_d_q;
            end
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            ac_q     <= ac_d;
            flags_q  <= flags_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            d_out_q  <= d_out_d;
            d_oe_q   <= d_oe_d;
            mem_q    <= mem_d;
        end
    end

    assign busy       = is_busy;
    assign disp_char  = mem_q[disp_addr];
    assign disp_on    = flags_q.disp_on;
    assign cursor_on  = flags_q.cursor_on;
    assign blink_on   = flags_q.blink_on;
    assign inc_mode   = flags_q.inc_mode;
    assign shift_mode = flags_q.shift_mode;
    assign func_8bit  = flags_q.func_8bit;
    assign func_2line = flags_q.func_2line;
    assign cmd_strobe = strobe_q;
    assign err_busy   = err_q;
    assign lcd_d_out  = d_out_q;
    assign lcd_d_oe   = d_oe_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Scoreboard bench for lcd_bus_rx: directed bus transactions, monitor checks every strobe/error.
module tb_lcd_bus_rx;

    localparam int CMD = 20;
    localparam int CLR = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_d_in = 8'h00;
    logic [7:0] lcd_d_out;
    logic       lcd_d_oe;
    logic [4:0] disp_addr = 5'd0;
    logic [7:0] disp_char;
    logic       busy, disp_on, cursor_on, blink_on, inc_mode, shift_mode, func_8bit, func_2line;
    logic       cmd_strobe, err_busy;

    lcd_bus_rx #(
        .BUSY_CMD_CYC(CMD),
        .BUSY_CLR_CYC(CLR),
        .LINE_LEN    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_d_in  (lcd_d_in),
        .lcd_d_out (lcd_d_out),
        .lcd_d_oe  (lcd_d_oe),
        .disp_addr (disp_addr),
        .disp_char (disp_char),
        .busy      (busy),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .inc_mode  (inc_mode),
        .shift_mode(shift_mode),
        .func_8bit (func_8bit),
        .func_2line(func_2line),
        .cmd_strobe(cmd_strobe),
        .err_busy  (err_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [6:0] flags;
        int         busy_len;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [6:0] exp_flags = 7'b0001010;
    logic [7:0] exp_mem [32];
    logic [6:0] act_flags;

    assign act_flags = {disp_on, cursor_on, blink_on, inc_mode, shift_mode, func_8bit, func_2line};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic push(input bit err, input logic [6:0] fl, input int len);
        exp_t e;
        e.err      = err;
        e.flags    = fl;
        e.busy_len = len;
        sb.push_back(e);
    endtask

    task automatic bus_wr(input logic rs, input logic [7:0] d);
        lcd_rs   = rs;
        lcd_rw   = 1'b0;
        lcd_d_in = d;
        repeat (2) @(posedge clk);
        #2 lcd_en = 1'b1;
        repeat (4) @(posedge clk);
        #2 lcd_en = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic wr_cmd(input logic [7:0] d, input logic [6:0] fl, input int len);
        exp_flags = fl;
        push(1'b0, fl, len);
        bus_wr(1'b0, d);
        wait_idle();
    endtask

    task automatic wr_dat(input logic [7:0] d);
        push(1'b0, exp_flags, CMD);
        bus_wr(1'b1, d);
        wait_idle();
    endtask

    // Status read: returns {busy, AC} when reads are built in, else the bus stays undriven
    task automatic rd_ac(input logic [7:0] exp_ac);
        logic [7:0] want_out;
        logic       want_oe;
`ifdef LCD_READ_EN
        want_out = exp_ac;
        want_oe  = 1'b1;
        push(1'b0, exp_flags, 0);
`else
        want_out = exp_ac & 8'h00;
        want_oe  = 1'b0;
`endif
        lcd_rs = 1'b0;
        lcd_rw = 1'b1;
        repeat (2) @(posedge clk);
        #2 lcd_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rd_oe", lcd_d_oe, want_oe);
        chk("rd_data", lcd_d_out, want_out);
        #2 lcd_en = 1'b0;
        repeat (6) @(posedge clk);
        #2 lcd_rw = 1'b0;
        @(negedge clk);
        chk("rd_oe_release", lcd_d_oe, 1'b0);
    endtask

    task automatic check_mirror(input string tag);
        for (int i = 0; i < 32; i++) begin
            disp_addr = 5'(i);
            #1;
            chk($sformatf("%s mirror[%0d]", tag, i), disp_char, exp_mem[i]);
        end
    endtask

    // Monitor: pops one expectation per strobe/error pulse and times each busy window
    int   busy_cnt = 0;
    int   busy_exp = 0;
    logic busy_prev = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (cmd_strobe || err_busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {err_busy, cmd_strobe}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {err_busy, cmd_strobe}, e.err ? 2'b10 : 2'b01);
                    chk("flags", act_flags, e.flags);
                    if (!e.err && e.busy_len != 0) begin
                        busy_exp = e.busy_len;
                        busy_cnt = 0;
                    end
                end
            end
            if (busy) busy_cnt++;
            if (busy_prev && !busy) chk("busy_len", busy_cnt, busy_exp);
            busy_prev = busy;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", act_flags, 7'b0001010);
        chk("rst_pulses", {cmd_strobe, err_busy}, 2'b00);
        chk("rst_d_out", lcd_d_out, 8'h00);
        chk("rst_d_oe", lcd_d_oe, 1'b0);
        check_mirror("reset");
        rd_ac(8'h00);

        wr_cmd(8'h38, 7'b0001011, CMD);
        wr_cmd(8'h0F, 7'b1111011, CMD);
        wr_cmd(8'h01, 7'b1111011, CLR);
        wr_cmd(8'h06, 7'b1111011, CMD);

        wr_dat(8'h31); exp_mem[0] = 8'h31;
        wr_dat(8'h32); exp_mem[1] = 8'h32;
        wr_dat(8'h33); exp_mem[2] = 8'h33;
        rd_ac(8'h03);
        wr_dat(8'h34); exp_mem[3] = 8'h34;
        check_mirror("line0");

        wr_cmd(8'hC0, exp_flags, CMD);
        wr_dat(8'h35); exp_mem[16] = 8'h35;
        rd_ac(8'h41);
        wr_dat(8'h36); exp_mem[17] = 8'h36;

        // Second write lands inside the first one's busy window
        push(1'b0, exp_flags, CMD);
        bus_wr(1'b1, 8'h37); exp_mem[18] = 8'h37;
        push(1'b1, exp_flags, 0);
        bus_wr(1'b1, 8'h58);
        wait_idle();
        wr_dat(8'h39); exp_mem[19] = 8'h39;
        check_mirror("busy_err");

        wr_cmd(8'hA7, exp_flags, CMD);
        wr_dat(8'h41);
        rd_ac(8'h40);
        wr_dat(8'h42); exp_mem[16] = 8'h42;
        check_mirror("wrap_up");

        wr_cmd(8'h04, 7'b1110011, CMD);
        wr_cmd(8'h80, exp_flags, CMD);
        wr_dat(8'h43); exp_mem[0] = 8'h43;
        rd_ac(8'h67);
        wr_cmd(8'hC0, exp_flags, CMD);
        wr_dat(8'h44); exp_mem[16] = 8'h44;
        rd_ac(8'h27);

        wr_cmd(8'h02, exp_flags, CLR);
        wr_dat(8'h45); exp_mem[0] = 8'h45;
        check_mirror("home");

        bus_wr(1'b0, 8'h00);
        @(negedge clk);
        chk("nop_busy", busy, 1'b0);

        wr_cmd(8'h01, 7'b1111011, CLR);
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        check_mirror("clear");
        rd_ac(8'h00);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
